// File: rtl/urv_uart_pkg.sv
// Shared types and register map for the uRV memory-mapped UART transmitter.
package urv_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int unsigned REG_DATA_OFS   = 0;
    localparam int unsigned REG_STATUS_OFS = 4;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_BUSY_BIT  = 2;
    localparam int unsigned STAT_LEVEL_LSB = 4;
    localparam int unsigned STAT_LEVEL_W   = 8;

endpackage

// File: rtl/urv_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
module urv_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign push_ok_c = push & ~full;
    assign pop_ok_c  = pop & ~empty;

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_c) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/urv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS registers, byte FIFO, serialiser FSM.
module urv_uart_tx
    import urv_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        txd_o
);
    localparam int unsigned BAUD_W    = $clog2(BAUD_DIV);
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] DATA_ADDR = BASE_ADDR + 32'(REG_DATA_OFS);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'(REG_STATUS_OFS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    logic             data_hit_c;
    logic             stat_hit_c;
    logic             push_c;
    logic             pop_c;
    logic             ld_req_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       fifo_rdata;
    logic [31:0]      status_c;
    logic             unused_bus_bits;

    tx_state_e        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             load_done_q;
    logic [31:0]      data_l_q;

    assign unused_bus_bits = ^{dm_data_s_i[31:8], dm_data_select_i[3:1]};

    assign data_hit_c = (dm_addr_i == DATA_ADDR);
    assign stat_hit_c = (dm_addr_i == STAT_ADDR);

    // Back-pressure only on a real byte push into a full FIFO.
    assign push_c          = dm_store_i & data_hit_c & dm_data_select_i[0] & ~fifo_full;
    assign dm_store_done_o = ~(dm_store_i & data_hit_c & dm_data_select_i[0] & fifo_full);

    urv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (dm_data_s_i[7:0]),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        status_c = '0;
        status_c[STAT_EMPTY_BIT] = fifo_empty;
        status_c[STAT_FULL_BIT]  = fifo_full;
        status_c[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
        status_c[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    end

    // One-cycle load response; a held request must drop or see done before repeating.
    assign ld_req_c = dm_load_i & (data_hit_c | stat_hit_c) & ~load_done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_done_q <= 1'b0;
            data_l_q    <= '0;
        end else begin
            load_done_q <= ld_req_c;
            data_l_q    <= (ld_req_c && stat_hit_c) ? status_c : '0;
        end
    end

    assign dm_load_done_o = load_done_q;
    assign dm_data_l_o    = data_l_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // txd_d is the line level for the state being entered, so txd_o stays registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign txd_o = txd_q;

endmodule

// File: tb/tb_urv_uart_tx.sv
// Bench for urv_uart_tx: frame-level model of the TX line and register file, checked every cycle.
module tb_urv_uart_tx;
    localparam int unsigned BD    = 16;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk_i;
    logic        rst_n_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic [31:0] dm_data_l_o;
    logic        dm_store_done_o;
    logic        dm_load_done_o;
    logic        txd_o;

    urv_uart_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_store_i       (dm_store_i),
        .dm_load_i        (dm_load_i),
        .dm_data_l_o      (dm_data_l_o),
        .dm_store_done_o  (dm_store_done_o),
        .dm_load_done_o   (dm_load_done_o),
        .txd_o            (txd_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of waiting bytes, the byte on the wire and its position in the 10-bit frame.
    logic [7:0]  m_q[$];
    bit          m_busy;
    int          m_t;
    logic [7:0]  m_cur;
    logic        m_ld_done;
    logic [31:0] m_ld_data;

    function automatic logic exp_txd();
        int b;
        if (!m_busy) return 1'b1;
        b = m_t / BD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0]    = (m_q.size() == 0);
        s[1]    = (m_q.size() == DEPTH);
        s[2]    = m_busy;
        s[11:4] = 8'(m_q.size());
        return s;
    endfunction

    task automatic model_step();
        bit          hit_d, hit_s, push, nd;
        logic [31:0] st;
        hit_d = (dm_addr_i == BASE);
        hit_s = (dm_addr_i == BASE + 32'd4);
        push  = dm_store_i && hit_d && dm_data_select_i[0] && (m_q.size() < DEPTH);
        st    = exp_status();
        nd    = dm_load_i && (hit_d || hit_s) && !m_ld_done;
        m_ld_done = nd;
        m_ld_data = (nd && hit_s) ? st : 32'd0;
        if (!m_busy) begin
            if (m_q.size() > 0) begin
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else if (m_t == 10 * BD - 1) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_t   = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_t++;
        end
        if (push) m_q.push_back(dm_data_s_i[7:0]);
    endtask

    // Compare process: outputs checked at every falling edge, then the model advances.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                m_q.delete();
                m_busy    = 1'b0;
                m_t       = 0;
                m_ld_done = 1'b0;
                m_ld_data = '0;
                check("rst_load_data", dm_data_l_o, 32'd0);
            end
            check("txd", 32'(txd_o), 32'(exp_txd()));
            check("store_done", 32'(dm_store_done_o),
                  32'(!(dm_store_i && dm_addr_i == BASE && dm_data_select_i[0] && m_q.size() == DEPTH)));
            check("load_done", 32'(dm_load_done_o), 32'(m_ld_done));
            if (m_ld_done) check("load_data", dm_data_l_o, m_ld_data);
            if (rst_n_i) model_step();
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [7:0] data,
                            input logic [3:0] sel, output int rejected);
        bit ok;
        bit done;
        rejected         = 0;
        done             = 1'b0;
        dm_addr_i        = addr;
        dm_data_s_i      = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 8'h00} | 32'(data);
        dm_data_select_i = sel;
        dm_store_i       = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_i);
            ok = dm_store_done_o;
            cycle();
            if (ok) begin
                done = 1'b1;
                break;
            end
            rejected++;
        end
        dm_store_i = 1'b0;
        check("store_handshake", 32'(done), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] addr, input bit hold, output logic [31:0] data);
        bit got;
        got       = 1'b0;
        data      = 'x;
        dm_addr_i = addr;
        dm_load_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (dm_load_done_o) begin
                got  = 1'b1;
                data = dm_data_l_o;
                break;
            end
        end
        check("load_handshake", 32'(got), 32'd1);
        if (hold) begin
            cycle();
            check("load_no_repeat", 32'(dm_load_done_o), 32'd0);
        end
        dm_load_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (!m_busy && m_q.size() == 0) begin
                idle = 1'b1;
                break;
            end
            cycle();
        end
        check("drain", 32'(idle), 32'd1);
        repeat (3) cycle();
    endtask

    initial begin
        int          rej;
        int          rej_sum;
        logic [31:0] rd;
        logic [9:0]  sb;
        logic [29:0] b2b;
        logic [29:0] b2b_exp;

        rst_n_i          = 1'b0;
        dm_addr_i        = '0;
        dm_data_s_i      = '0;
        dm_data_select_i = '0;
        dm_store_i       = 1'b0;
        dm_load_i        = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        check("reset_txd", 32'(txd_o), 32'd1);
        check("reset_load_done", 32'(dm_load_done_o), 32'd0);
        check("reset_load_data", dm_data_l_o, 32'd0);
        check("reset_store_done", 32'(dm_store_done_o), 32'd1);
        cycle();

        // Single 0x55 byte: start bit one cycle after accept, alternating line pattern.
        do_store(BASE, 8'h55, 4'b0001, rej);
        check("sb_txd_at_accept", 32'(txd_o), 32'd1);
        cycle();
        check("sb_txd_start", 32'(txd_o), 32'd0);
        repeat (7) cycle();
        for (int i = 0; i < 10; i++) begin
            sb[i] = txd_o;
            repeat (BD) cycle();
        end
        check("sb_pattern", 32'(sb), 32'(10'b10_1010_1010));
        wait_idle();
        do_load(BASE + 32'd4, 1'b0, rd);
        check("sb_status", rd, 32'h0000_0001);

        // Three contiguous frames.
        do_store(BASE, 8'h41, 4'b0001, rej);
        do_store(BASE, 8'h42, 4'b0001, rej);
        do_store(BASE, 8'h43, 4'b0001, rej);
        repeat (6) cycle();
        for (int i = 0; i < 30; i++) begin
            b2b[i] = txd_o;
            repeat (BD) cycle();
        end
        b2b_exp = {1'b1, 8'h43, 1'b0, 1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0};
        check("b2b_frames", 32'(b2b), 32'(b2b_exp));
        check("b2b_idle_after", 32'(txd_o), 32'd1);
        wait_idle();

        // Ten stores: the tenth stalls until the first frame's stop bit ends.
        rej_sum = 0;
        for (int i = 0; i < 10; i++) begin
            do_store(BASE, 8'(8'h60 + i), 4'b0001, rej);
            if (i < 9) rej_sum += rej;
        end
        check("bp_first9_no_stall", 32'(rej_sum), 32'd0);
        check("bp_tenth_stall", 32'(rej), 32'd153);
        do_load(BASE + 32'd4, 1'b0, rd);
        check("bp_status_full", rd, 32'h0000_0086);
        wait_idle();

        // Status mid-frame with two bytes waiting.
        do_store(BASE, 8'h11, 4'b0001, rej);
        do_store(BASE, 8'h22, 4'b0001, rej);
        do_store(BASE, 8'h33, 4'b0001, rej);
        repeat (40) cycle();
        do_load(BASE + 32'd4, 1'b1, rd);
        check("st_status", rd, 32'h0000_0024);
        wait_idle();

        // Ignored accesses.
        do_store(BASE, 8'h99, 4'b0010, rej);
        check("ign_sel_done", 32'(rej), 32'd0);
        do_store(BASE + 32'd8, 8'h77, 4'b1111, rej);
        check("ign_addr_done", 32'(rej), 32'd0);
        do_store(BASE + 32'd4, 8'h66, 4'b1111, rej);
        check("ign_status_store_done", 32'(rej), 32'd0);
        repeat (3) cycle();
        check("ign_txd_idle", 32'(txd_o), 32'd1);
        do_load(BASE + 32'd4, 1'b0, rd);
        check("ign_status", rd, 32'h0000_0001);
        do_load(BASE, 1'b1, rd);
        check("ign_data_load", rd, 32'd0);

        // Reset during data bit 3 of 0xA5 (a zero bit), with a second byte queued.
        do_store(BASE, 8'hA5, 4'b0001, rej);
        do_store(BASE, 8'h3C, 4'b0001, rej);
        repeat (70) cycle();
        check("rst_pre_txd", 32'(txd_o), 32'd0);
        rst_n_i = 1'b0;
        #1;
        check("rst_async_txd", 32'(txd_o), 32'd1);
        repeat (3) cycle();
        rst_n_i = 1'b1;
        repeat (200) cycle();
        do_load(BASE + 32'd4, 1'b0, rd);
        check("rst_status", rd, 32'h0000_0001);

        // Randomised traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [31:0] a;
            logic [3:0]  sel;
            op = $urandom_range(0, 9);
            if (op <= 6) begin
                case ($urandom_range(0, 9))
                    0:       a = BASE + 32'd4;
                    1:       a = BASE + 32'(4 * $urandom_range(2, 40));
                    default: a = BASE;
                endcase
                sel = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) sel[0] = 1'b1;
                do_store(a, 8'($urandom_range(0, 255)), sel, rej);
            end else if (op <= 8) begin
                a = ($urandom_range(0, 1) == 1) ? BASE + 32'd4 : BASE;
                do_load(a, bit'($urandom_range(0, 1)), rd);
            end else begin
                repeat ($urandom_range(0, 40)) cycle();
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
